// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Safety stage placed directly after the traffic light controller. Each clock
// it samples the four {red,yellow,green} light vectors and checks them for:
// valid one-hot encoding, mutual exclusion of non-red approaches, legal
// per-approach sequencing, minimum yellow length and all-red stalls. Clean
// samples are forwarded to the lamp drivers one cycle later. The first
// violation latches a fault code and the lamps flash all-red until the fault
// is acknowledged with fault_clr. An offending sample is never forwarded.
//
// Ports
//   clk                       system clock, rising edge
//   rst                       asynchronous, active-high reset
//   north/west/south/east_light  controller outputs {red,yellow,green}
//   fault_clr                 one-cycle fault acknowledge (used only in fault)
//   north/west/south/east_lamp   registered lamp drives {red,yellow,green}
//   fault                     high while the monitor holds a fault
//   fault_code                first fault cause (1..5), 0 when no fault
// -----------------------------------------------------------------------------
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_ALLRED = 16,
  parameter int FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north_light,
  input  logic [2:0] west_light,
  input  logic [2:0] south_light,
  input  logic [2:0] east_light,
  input  logic       fault_clr,
  output logic [2:0] north_lamp,
  output logic [2:0] west_lamp,
  output logic [2:0] south_lamp,
  output logic [2:0] east_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  mon_state_t state;

  logic [2:0] light      [4];
  logic [2:0] lamp       [4];
  logic [2:0] prev_light [4];
  logic [7:0] yel_cnt    [4];
  logic [7:0] allred_cnt;
  logic [7:0] flash_cnt;
  logic       flash_on;   // 1: flash phase currently showing red

  logic       any_invalid;
  logic [2:0] nonred_cnt;
  logic       any_illegal;
  logic       any_short;
  logic       all_red;
  logic       allred_over;
  logic [2:0] viol_code;

  // Index order 0..3 = north, west, south, east.
  assign light[0] = north_light;
  assign light[1] = west_light;
  assign light[2] = south_light;
  assign light[3] = east_light;

  assign north_lamp = lamp[0];
  assign west_lamp  = lamp[1];
  assign south_lamp = lamp[2];
  assign east_lamp  = lamp[3];

  function automatic logic is_valid(input logic [2:0] code);
    return (code == RED) || (code == YEL) || (code == GRN);
  endfunction

  // Hold, red->green, green->yellow and yellow->red are the only legal moves.
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (cur == prev) ||
           ((prev == RED) && (cur == GRN)) ||
           ((prev == GRN) && (cur == YEL)) ||
           ((prev == YEL) && (cur == RED));
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Violation detection on the current sample; lowest code wins.
  always_comb begin
    any_invalid = 1'b0;
    nonred_cnt  = 3'd0;
    any_illegal = 1'b0;
    any_short   = 1'b0;
    all_red     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      any_invalid = any_invalid | ~is_valid(light[i]);
      nonred_cnt  = nonred_cnt + {2'b00, (light[i] != RED)};
      any_illegal = any_illegal | ~legal_step(prev_light[i], light[i]);
      // Yellow length uses the count accumulated before this red sample.
      any_short   = any_short | ((prev_light[i] == YEL) && (light[i] == RED) &&
                                 (yel_cnt[i] < 8'(MIN_YELLOW)));
      all_red     = all_red & (light[i] == RED);
    end
    // This all-red cycle would be number allred_cnt+1.
    allred_over = all_red && (allred_cnt >= 8'(MAX_ALLRED));

    if (any_invalid) begin
      viol_code = 3'd1;
    end else if (nonred_cnt > 3'd1) begin
      viol_code = 3'd2;
    end else if (any_illegal) begin
      viol_code = 3'd3;
    end else if (any_short) begin
      viol_code = 3'd4;
    end else if (allred_over) begin
      viol_code = 3'd5;
    end else begin
      viol_code = 3'd0;
    end
  end

  // Monitor FSM, history, counters and registered lamp/fault outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MON_INIT;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      allred_cnt <= 8'd0;
      flash_cnt  <= 8'd0;
      flash_on   <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        lamp[i]       <= RED;
        prev_light[i] <= RED;
        yel_cnt[i]    <= 8'd0;
      end
    end else begin
      case (state)
        MON_INIT: begin
          state      <= MON_RUN;
          fault      <= 1'b0;
          fault_code <= 3'd0;
          allred_cnt <= 8'd0;
          flash_cnt  <= 8'd0;
          flash_on   <= 1'b1;
          for (int i = 0; i < 4; i++) begin
            lamp[i]       <= RED;
            prev_light[i] <= light[i];
            yel_cnt[i]    <= 8'd0;
          end
        end

        MON_RUN: begin
          if (viol_code != 3'd0) begin
            state      <= MON_FAULT;
            fault      <= 1'b1;
            fault_code <= viol_code;
            flash_cnt  <= 8'd0;
            flash_on   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              lamp[i] <= RED;
            end
          end else begin
            allred_cnt <= all_red ? sat_inc(allred_cnt) : 8'd0;
            for (int i = 0; i < 4; i++) begin
              lamp[i]       <= light[i];
              prev_light[i] <= light[i];
              yel_cnt[i]    <= (light[i] == YEL) ? sat_inc(yel_cnt[i]) : 8'd0;
            end
          end
        end

        MON_FAULT: begin
          if (fault_clr) begin
            state      <= MON_INIT;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash_cnt  <= 8'd0;
            flash_on   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              lamp[i] <= RED;
            end
          end else if (flash_cnt == 8'(FLASH_HALF - 1)) begin
            flash_cnt <= 8'd0;
            flash_on  <= ~flash_on;
            for (int i = 0; i < 4; i++) begin
              lamp[i] <= flash_on ? DARK : RED;
            end
          end else begin
            flash_cnt <= flash_cnt + 8'd1;
          end
        end

        default: begin
          // Unreachable encoding: fall back to the safe restart path.
          state      <= MON_INIT;
          fault      <= 1'b0;
          fault_code <= 3'd0;
          flash_cnt  <= 8'd0;
          flash_on   <= 1'b1;
          for (int i = 0; i < 4; i++) begin
            lamp[i] <= RED;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

  localparam logic [2:0]  R = 3'b100;
  localparam logic [2:0]  Y = 3'b010;
  localparam logic [2:0]  G = 3'b001;
  localparam logic [11:0] ALL_RED  = 12'h924;
  localparam logic [11:0] ALL_DARK = 12'h000;
  localparam logic [11:0] ALL_BAD  = 12'hFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] north_light = R;
  logic [2:0] west_light  = R;
  logic [2:0] south_light = R;
  logic [2:0] east_light  = R;
  logic [2:0] north_lamp, west_lamp, south_lamp, east_lamp;
  logic       fault;
  logic [2:0] fault_code;

  traffic_conflict_monitor #(
    .MIN_YELLOW(3),
    .MAX_ALLRED(16),
    .FLASH_HALF(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .north_light(north_light),
    .west_light (west_light),
    .south_light(south_light),
    .east_light (east_light),
    .fault_clr  (fault_clr),
    .north_lamp (north_lamp),
    .west_lamp  (west_lamp),
    .south_lamp (south_lamp),
    .east_lamp  (east_lamp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] lamps;
    logic        flt;
    logic [2:0]  code;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] lamps_now();
    return {north_lamp, west_lamp, south_lamp, east_lamp};
  endfunction

  // Approach a (0=N,1=W,2=S,3=E) shows code c, all others red.
  function automatic logic [11:0] one(input int a, input logic [2:0] c);
    logic [11:0] v;
    v = ALL_RED;
    v[(3 - a) * 3 +: 3] = c;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expected outputs, compare after the edge.
  task automatic step(input string tag, input logic [11:0] lights, input logic clr,
                      input logic [11:0] exp_l, input logic exp_f, input logic [2:0] exp_c);
    exp_t e;
    {north_light, west_light, south_light, east_light} = lights;
    fault_clr = clr;
    e.lamps = exp_l;
    e.flt   = exp_f;
    e.code  = exp_c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    e = sb.pop_front();
    check_value({tag, " lamps"}, {20'd0, lamps_now()}, {20'd0, e.lamps});
    check_value({tag, " fault"}, {31'd0, fault}, {31'd0, e.flt});
    check_value({tag, " code"},  {29'd0, fault_code}, {29'd0, e.code});
  endtask

  task automatic ok(input string tag, input logic [11:0] lights);
    step(tag, lights, 1'b0, lights, 1'b0, 3'd0);
  endtask

  // Acknowledge the fault, then pass through the single INIT cycle.
  task automatic recover();
    step("clr", ALL_RED, 1'b1, ALL_RED, 1'b0, 3'd0);
    step("init", ALL_RED, 1'b0, ALL_RED, 1'b0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check_value("reset lamps", {20'd0, lamps_now()}, {20'd0, ALL_RED});
    check_value("reset fault", {31'd0, fault}, 32'd0);
    check_value("reset code",  {29'd0, fault_code}, 32'd0);
    #14 rst = 1'b0;

    step("init0", ALL_RED, 1'b0, ALL_RED, 1'b0, 3'd0);

    // T1: legal cycle on every approach, lamps follow with one cycle latency
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k < 40; k++) ok("t1_green", one(a, G));
      for (int k = 0; k < 5; k++)  ok("t1_yellow", one(a, Y));
      for (int k = 0; k < 2; k++)  ok("t1_allred", ALL_RED);
    end

    // T2: two greens -> code 2, then flash with inputs ignored and code frozen
    step("t2_entry", {G, R, R, G}, 1'b0, ALL_RED, 1'b1, 3'd2);
    for (int k = 0; k < 7; k++) step("t2_flash_red", ALL_BAD, 1'b0, ALL_RED, 1'b1, 3'd2);
    for (int k = 0; k < 8; k++) step("t2_flash_dark", ALL_BAD, 1'b0, ALL_DARK, 1'b1, 3'd2);
    step("t2_flash_red2", ALL_RED, 1'b0, ALL_RED, 1'b1, 3'd2);

    // T6 (clear): INIT then tracking resumes
    recover();
    ok("t6_track", one(0, G));

    // T3: yellow for 2 cycles is too short, 3 is fine
    ok("t3_y1", one(0, Y));
    ok("t3_y2", one(0, Y));
    step("t3_short", ALL_RED, 1'b0, ALL_RED, 1'b1, 3'd4);
    recover();
    ok("t3_g", one(0, G));
    for (int k = 0; k < 3; k++) ok("t3_y", one(0, Y));
    ok("t3_red_ok", ALL_RED);

    // T4: invalid encoding outranks a simultaneous illegal green->red
    ok("t4_g", one(1, G));
    step("t4_invalid", {3'b011, R, R, R}, 1'b0, ALL_RED, 1'b1, 3'd1);
    recover();

    // Illegal green->red on its own
    ok("ill_g", one(1, G));
    step("ill_jump", ALL_RED, 1'b0, ALL_RED, 1'b1, 3'd3);
    recover();

    // T5: 16 all-red cycles tolerated, the 17th faults
    for (int k = 0; k < 16; k++) ok("t5_16red", ALL_RED);
    ok("t5_g", one(0, G));
    for (int k = 0; k < 3; k++) ok("t5_y", one(0, Y));
    for (int k = 0; k < 16; k++) ok("t5_red", ALL_RED);
    step("t5_stall", ALL_RED, 1'b0, ALL_RED, 1'b1, 3'd5);

    // T6 (reset): async reset in the dark flash phase
    for (int k = 0; k < 7; k++) step("t6_flash_red", ALL_RED, 1'b0, ALL_RED, 1'b1, 3'd5);
    step("t6_flash_dark", ALL_RED, 1'b0, ALL_DARK, 1'b1, 3'd5);
    #1 rst = 1'b1;
    #1;
    check_value("t6_rst lamps", {20'd0, lamps_now()}, {20'd0, ALL_RED});
    check_value("t6_rst fault", {31'd0, fault}, 32'd0);
    check_value("t6_rst code",  {29'd0, fault_code}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step("t6_init", one(2, G), 1'b0, ALL_RED, 1'b0, 3'd0);
    ok("t6_run", one(2, G));
    ok("t6_run_y", one(2, Y));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
